latch_id_ex: RTL and testbench
==============================

// Module: latch_id_ex
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core. Captures decode-stage operands, register
//  addresses, extended immediate, shamt and control bits each enabled cycle; feeds the EX stage,
//  including the idex operand inputs of the ALU operand forwarding muxes and the forwarding unit.
//  Supports debug-unit stepping, load-use stall (hold) and flush (bubble insertion).
// PARAMETERS
//  BITS_SIZE      32  datapath width (operands, immediate, PC)
//  BITS_REGS      5   register-address width (rs/rt/rd/shamt)
//  BITS_ALUOP     3   ALU-op control field width
// PORTS
//  i_clk          in   1          core clock, rising edge
//  i_reset        in   1          asynchronous, active-high reset
//  i_step         in   1          debug-unit global enable; 0 => all state frozen
//  i_stall        in   1          hazard unit: hold current contents
//  i_flush        in   1          hazard/branch: load a bubble
//  i_pc4          in   BITS_SIZE  PC+4 of the decoded instruction
//  i_register1    in   BITS_SIZE  regfile read data rs
//  i_register2    in   BITS_SIZE  regfile read data rt
//  i_extension    in   BITS_SIZE  sign/zero-extended immediate
//  i_rs/i_rt/i_rd in   BITS_REGS  register addresses
//  i_shamt        in   BITS_REGS  shift amount field
//  i_ctrl_regdst  in   2          00 rt, 01 rd, 10 $31
//  i_ctrl_alusrc  in   1          ALU B from immediate
//  i_ctrl_aluop   in   BITS_ALUOP ALU operation class
//  i_ctrl_memrd/i_ctrl_memwr/i_ctrl_regwr/i_ctrl_memtoreg  in 1 each
//  o_*            out  same       registered copy of every i_* data/ctrl input (o_idex_register1, ...)
//  o_shamt_ext    out  BITS_SIZE  o_shamt zero-extended to BITS_SIZE
//  o_valid        out  1          1 = stage holds a real instruction, 0 = bubble
// BEHAVIOUR
//  - i_reset=1 (async): every output 0, o_valid=0; takes effect immediately, mid-stall included.
//  - Per rising edge, priority: i_step=0 -> hold all (flush/stall ignored);
//    else i_flush=1 -> bubble; else i_stall=1 -> hold; else capture all inputs, o_valid<=1.
//  - Bubble: o_ctrl_regwr/memrd/memwr/memtoreg=0, aluop=0, regdst=00, alusrc=0, o_rs/o_rt/o_rd=0
//    (no spurious forwarding match on $0), o_valid=0; data fields (pc4, registers, extension)
//    also 0.
//  - Flush and stall simultaneously: flush wins.
//  - Latency exactly 1 enabled cycle input->output; no combinational input->output paths
//    except o_shamt_ext = {{(BITS_SIZE-BITS_REGS){1'b0}}, o_shamt}.
//  - Hold preserves o_valid; a held bubble stays a bubble.
//  - No arithmetic; widths pass straight through, no truncation.
// STRUCTURE
//  - Shared package/header: BITS_SIZE, BITS_REGS, BITS_ALUOP, REGDST_RT/RD/RA codes, bubble
//    control constant.
//  - One flat module; one always block for data, one for control+valid, sharing a
//    3-way next-state select (hold/bubble/load). No sub-module needed.
// TESTING
//  1. Reset asserted between edges -> all outputs 0 immediately, o_valid=0.
//  2. step=1, register1=32'hDEADBEEF, rd=5'd9, regwr=1 -> next edge o_idex_register1=DEADBEEF,
//     o_rd=9, o_ctrl_regwr=1, o_valid=1.
//  3. Loaded state, step=1, stall=1, inputs changed to 32'h1 -> outputs unchanged 3 edges.
//  4. Loaded state, flush=1 with stall=1 -> next edge regwr=memwr=memrd=0, o_rd=0, o_valid=0.
//  5. step=0 with flush=1 and new inputs -> nothing changes; step=1 next edge -> bubble loaded.
//  6. shamt=5'd31 captured -> o_shamt_ext=32'h0000001F; reset mid-stall -> all 0 at once.

Source files
------------

// File: rtl/latch_id_ex_pkg.sv
// Shared widths, register-destination codes and bubble constants for the ID/EX pipeline register.
package latch_id_ex_pkg;

    localparam int BITS_SIZE  = 32;
    localparam int BITS_REGS  = 5;
    localparam int BITS_ALUOP = 3;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    typedef struct packed {
        logic [1:0]            regdst;
        logic                  alusrc;
        logic [BITS_ALUOP-1:0] aluop;
        logic                  memrd;
        logic                  memwr;
        logic                  regwr;
        logic                  memtoreg;
    } ctrl_t;

    // A bubble must not write anything or touch memory.
    localparam ctrl_t CTRL_BUBBLE = '{
        regdst:   REGDST_RT,
        alusrc:   1'b0,
        aluop:    '0,
        memrd:    1'b0,
        memwr:    1'b0,
        regwr:    1'b0,
        memtoreg: 1'b0
    };

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_BUBBLE = 2'd1,
        SEL_LOAD   = 2'd2
    } sel_t;

    // Debug step gates everything; flush outranks stall.
    function automatic sel_t next_sel(input logic step, input logic flush, input logic stall);
        sel_t sel;
        if (!step)      sel = SEL_HOLD;
        else if (flush) sel = SEL_BUBBLE;
        else if (stall) sel = SEL_HOLD;
        else            sel = SEL_LOAD;
        return sel;
    endfunction

endpackage

// File: rtl/latch_id_ex.sv
// ID/EX pipeline register: captures decode operands/addresses/control once per enabled cycle,
// with debug stepping, load-use hold and bubble insertion on flush.
module latch_id_ex
    import latch_id_ex_pkg::*;
#(
    parameter int BITS_SIZE = latch_id_ex_pkg::BITS_SIZE,
    parameter int BITS_REGS = latch_id_ex_pkg::BITS_REGS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_step,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [BITS_SIZE-1:0]  i_pc4,
    input  logic [BITS_SIZE-1:0]  i_register1,
    input  logic [BITS_SIZE-1:0]  i_register2,
    input  logic [BITS_SIZE-1:0]  i_extension,
    input  logic [BITS_REGS-1:0]  i_rs,
    input  logic [BITS_REGS-1:0]  i_rt,
    input  logic [BITS_REGS-1:0]  i_rd,
    input  logic [BITS_REGS-1:0]  i_shamt,
    input  logic [1:0]            i_ctrl_regdst,
    input  logic                  i_ctrl_alusrc,
    input  logic [BITS_ALUOP-1:0] i_ctrl_aluop,
    input  logic                  i_ctrl_memrd,
    input  logic                  i_ctrl_memwr,
    input  logic                  i_ctrl_regwr,
    input  logic                  i_ctrl_memtoreg,
    output logic [BITS_SIZE-1:0]  o_pc4,
    output logic [BITS_SIZE-1:0]  o_idex_register1,
    output logic [BITS_SIZE-1:0]  o_idex_register2,
    output logic [BITS_SIZE-1:0]  o_extension,
    output logic [BITS_REGS-1:0]  o_rs,
    output logic [BITS_REGS-1:0]  o_rt,
    output logic [BITS_REGS-1:0]  o_rd,
    output logic [BITS_REGS-1:0]  o_shamt,
    output logic [BITS_SIZE-1:0]  o_shamt_ext,
    output logic [1:0]            o_ctrl_regdst,
    output logic                  o_ctrl_alusrc,
    output logic [BITS_ALUOP-1:0] o_ctrl_aluop,
    output logic                  o_ctrl_memrd,
    output logic                  o_ctrl_memwr,
    output logic                  o_ctrl_regwr,
    output logic                  o_ctrl_memtoreg,
    output logic                  o_valid
);

    sel_t  sel;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  valid_q;

    assign sel = next_sel(i_step, i_flush, i_stall);

    assign ctrl_d = '{
        regdst:   i_ctrl_regdst,
        alusrc:   i_ctrl_alusrc,
        aluop:    i_ctrl_aluop,
        memrd:    i_ctrl_memrd,
        memwr:    i_ctrl_memwr,
        regwr:    i_ctrl_regwr,
        memtoreg: i_ctrl_memtoreg
    };

    // Data fields; register addresses are cleared on a bubble so the forwarding unit never
    // matches a stale rs/rt/rd.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pc4            <= '0;
            o_idex_register1 <= '0;
            o_idex_register2 <= '0;
            o_extension      <= '0;
            o_rs             <= '0;
            o_rt             <= '0;
            o_rd             <= '0;
            o_shamt          <= '0;
        end else begin
            case (sel)
                SEL_LOAD: begin
                    o_pc4            <= i_pc4;
                    o_idex_register1 <= i_register1;
                    o_idex_register2 <= i_register2;
                    o_extension      <= i_extension;
                    o_rs             <= i_rs;
                    o_rt             <= i_rt;
                    o_rd             <= i_rd;
                    o_shamt          <= i_shamt;
                end
                SEL_BUBBLE: begin
                    o_pc4            <= '0;
                    o_idex_register1 <= '0;
                    o_idex_register2 <= '0;
                    o_extension      <= '0;
                    o_rs             <= '0;
                    o_rt             <= '0;
                    o_rd             <= '0;
                    o_shamt          <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
        end else begin
            case (sel)
                SEL_LOAD: begin
                    ctrl_q  <= ctrl_d;
                    valid_q <= 1'b1;
                end
                SEL_BUBBLE: begin
                    ctrl_q  <= CTRL_BUBBLE;
                    valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ctrl_regdst   = ctrl_q.regdst;
    assign o_ctrl_alusrc   = ctrl_q.alusrc;
    assign o_ctrl_aluop    = ctrl_q.aluop;
    assign o_ctrl_memrd    = ctrl_q.memrd;
    assign o_ctrl_memwr    = ctrl_q.memwr;
    assign o_ctrl_regwr    = ctrl_q.regwr;
    assign o_ctrl_memtoreg = ctrl_q.memtoreg;
    assign o_valid         = valid_q;

    assign o_shamt_ext = {{(BITS_SIZE-BITS_REGS){1'b0}}, o_shamt};

endmodule

// File: tb/tb_latch_id_ex.sv
// Self-checking bench for latch_id_ex: directed scenarios plus randomized step/stall/flush traffic
// compared against a per-edge behavioural model.
module tb_latch_id_ex;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step, stall, flush;
    logic [31:0] pc4, r1, r2, ext;
    logic [4:0]  rs, rt, rd, shamt;
    logic [1:0]  regdst;
    logic        alusrc, memrd, memwr, regwr, memtoreg;
    logic [2:0]  aluop;

    logic [31:0] o_pc4, o_r1, o_r2, o_ext, o_shamt_ext;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [1:0]  o_regdst;
    logic        o_alusrc, o_memrd, o_memwr, o_regwr, o_memtoreg, o_valid;
    logic [2:0]  o_aluop;

    // Expected state of the register, one variable per output.
    logic [31:0] e_pc4, e_r1, e_r2, e_ext;
    logic [4:0]  e_rs, e_rt, e_rd, e_shamt;
    logic [1:0]  e_regdst;
    logic        e_alusrc, e_memrd, e_memwr, e_regwr, e_memtoreg, e_valid;
    logic [2:0]  e_aluop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    latch_id_ex dut (
        .i_clk(clk), .i_reset(rst), .i_step(step), .i_stall(stall), .i_flush(flush),
        .i_pc4(pc4), .i_register1(r1), .i_register2(r2), .i_extension(ext),
        .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt),
        .i_ctrl_regdst(regdst), .i_ctrl_alusrc(alusrc), .i_ctrl_aluop(aluop),
        .i_ctrl_memrd(memrd), .i_ctrl_memwr(memwr), .i_ctrl_regwr(regwr),
        .i_ctrl_memtoreg(memtoreg),
        .o_pc4(o_pc4), .o_idex_register1(o_r1), .o_idex_register2(o_r2), .o_extension(o_ext),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_shamt_ext(o_shamt_ext),
        .o_ctrl_regdst(o_regdst), .o_ctrl_alusrc(o_alusrc), .o_ctrl_aluop(o_aluop),
        .o_ctrl_memrd(o_memrd), .o_ctrl_memwr(o_memwr), .o_ctrl_regwr(o_regwr),
        .o_ctrl_memtoreg(o_memtoreg), .o_valid(o_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        {e_pc4, e_r1, e_r2, e_ext} = '0;
        {e_rs, e_rt, e_rd, e_shamt} = '0;
        {e_regdst, e_alusrc, e_aluop, e_memrd, e_memwr, e_regwr, e_memtoreg, e_valid} = '0;
    endtask

    // What one rising edge does, from the priority rules: step gates, flush beats stall.
    task automatic model_edge();
        if (!step) begin
        end else if (flush) begin
            model_clear();
        end else if (stall) begin
        end else begin
            e_pc4 = pc4; e_r1 = r1; e_r2 = r2; e_ext = ext;
            e_rs = rs; e_rt = rt; e_rd = rd; e_shamt = shamt;
            e_regdst = regdst; e_alusrc = alusrc; e_aluop = aluop;
            e_memrd = memrd; e_memwr = memwr; e_regwr = regwr; e_memtoreg = memtoreg;
            e_valid = 1'b1;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".pc4"},      64'(o_pc4),      64'(e_pc4));
        check({ctx, ".reg1"},     64'(o_r1),       64'(e_r1));
        check({ctx, ".reg2"},     64'(o_r2),       64'(e_r2));
        check({ctx, ".ext"},      64'(o_ext),      64'(e_ext));
        check({ctx, ".rs"},       64'(o_rs),       64'(e_rs));
        check({ctx, ".rt"},       64'(o_rt),       64'(e_rt));
        check({ctx, ".rd"},       64'(o_rd),       64'(e_rd));
        check({ctx, ".shamt"},    64'(o_shamt),    64'(e_shamt));
        check({ctx, ".shamtx"},   64'(o_shamt_ext), 64'(e_shamt));
        check({ctx, ".regdst"},   64'(o_regdst),   64'(e_regdst));
        check({ctx, ".alusrc"},   64'(o_alusrc),   64'(e_alusrc));
        check({ctx, ".aluop"},    64'(o_aluop),    64'(e_aluop));
        check({ctx, ".memrd"},    64'(o_memrd),    64'(e_memrd));
        check({ctx, ".memwr"},    64'(o_memwr),    64'(e_memwr));
        check({ctx, ".regwr"},    64'(o_regwr),    64'(e_regwr));
        check({ctx, ".memtoreg"}, 64'(o_memtoreg), 64'(e_memtoreg));
        check({ctx, ".valid"},    64'(o_valid),    64'(e_valid));
    endtask

    task automatic rand_inputs();
        pc4 = $urandom; r1 = $urandom; r2 = $urandom; ext = $urandom;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
        regdst = 2'($urandom_range(0, 2)); alusrc = 1'($urandom); aluop = 3'($urandom);
        memrd = 1'($urandom); memwr = 1'($urandom); regwr = 1'($urandom);
        memtoreg = 1'($urandom);
    endtask

    // Inputs are stable here (set after the previous sample point), so the model sees
    // exactly what the DUT captures.
    task automatic tick(input string ctx);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ctx);
    endtask

    initial begin
        step = 1'b0; stall = 1'b0; flush = 1'b0;
        rand_inputs();
        model_clear();
        #1;
        compare_all("reset");

        @(negedge clk);
        rst = 1'b0;

        // Load a known instruction.
        rand_inputs();
        step = 1'b1; r1 = 32'hDEAD_BEEF; rd = 5'd9; regwr = 1'b1;
        tick("load");
        check("load.reg1_k",  64'(o_r1),    64'h0000_0000_DEAD_BEEF);
        check("load.rd_k",    64'(o_rd),    64'd9);
        check("load.regwr_k", 64'(o_regwr), 64'd1);
        check("load.valid_k", 64'(o_valid), 64'd1);

        // Stall holds across three edges despite changed inputs.
        stall = 1'b1;
        pc4 = 32'h1; r1 = 32'h1; r2 = 32'h1; ext = 32'h1; rd = 5'd1;
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall.reg1_k", 64'(o_r1), 64'h0000_0000_DEAD_BEEF);
        check("stall.rd_k",   64'(o_rd), 64'd9);

        // Flush with stall: flush wins.
        memrd = 1'b1; memwr = 1'b1; regwr = 1'b1;
        flush = 1'b1;
        tick("flushstall");
        check("flush.regwr_k", 64'(o_regwr), 64'd0);
        check("flush.rd_k",    64'(o_rd),    64'd0);
        check("flush.valid_k", 64'(o_valid), 64'd0);

        // Held bubble stays a bubble.
        flush = 1'b0; stall = 1'b1;
        tick("heldbubble");

        // Reload, then step=0 freezes even a flush.
        stall = 1'b0; rand_inputs(); regwr = 1'b1;
        tick("reload");
        step = 1'b0; flush = 1'b1; rand_inputs();
        tick("frozen");
        check("frozen.valid_k", 64'(o_valid), 64'd1);
        step = 1'b1;
        tick("unfrozen");
        check("unfrozen.valid_k", 64'(o_valid), 64'd0);

        // Maximum shift amount, then reset in the middle of a stall.
        flush = 1'b0; rand_inputs(); shamt = 5'd31;
        tick("shamt");
        check("shamt.ext_k", 64'(o_shamt_ext), 64'h0000_0000_0000_001F);
        stall = 1'b1;
        tick("prerst");
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        compare_all("midrst");
        check("midrst.shamtx_k", 64'(o_shamt_ext), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;

        // Randomized control and data traffic.
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step  = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
